// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder/subtractor:
//   - state_t      : FSM state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH: default operand width of the top level
//   - nib_count()  : number of 4-bit nibbles in a WIDTH-bit operand
//   - clog2()      : ceiling log2 for constant sizing
//   - idx_width()  : width of the nibble index register (at least 1 bit)
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int nib_count(input int width);
        return width / 4;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // A one-nibble index still needs a 1-bit register to stay legal.
    function automatic int idx_width(input int nib);
        return (clog2(nib) < 1) ? 1 : clog2(nib);
    endfunction

endpackage

// File: rtl/fulladder_4b.sv
// -----------------------------------------------------------------------------
// fulladder_4b
// 4-bit carry-lookahead adder slice: S = A + B + Cex, CO = carry out of bit 3.
// Ports:
//   A, B : 4-bit addends
//   Cex  : carry in
//   S    : 4-bit sum
//   CO   : carry out
// -----------------------------------------------------------------------------
module fulladder_4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cex,
    output logic [3:0] S,
    output logic       CO
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is a flat sum of products of g/p and Cex, so no carry
    // depends on a lower carry signal.
    assign c[0] = Cex;
    assign c[1] = g[0] | (p[0] & Cex);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cex);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cex);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cex);

    assign S  = p ^ c[3:0];
    assign CO = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// WIDTH-bit adder/subtractor that reuses one 4-bit lookahead slice over
// WIDTH/4 cycles, least significant nibble first. WIDTH must be a multiple
// of 4 and at least 8.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only when not busy
//   a, b  : operands, captured on an accepted start
//   cin   : carry in for add (ignored for subtract)
//   sub   : 0 = a+b+cin, 1 = a-b; captured on an accepted start
//   busy  : high while nibbles are being processed
//   done  : one-cycle pulse, sum/cout/ovf valid
//   sum   : result (updates nibble by nibble during RUN)
//   cout  : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf   : two's-complement overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = nib_count(WIDTH);
    localparam int IW  = idx_width(NIB);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [IW+1:0]    base;
    logic             accept;
    logic             last;
    logic [3:0]       s_nib;
    logic             co;

    assign accept = (state != ST_RUN) && start;
    assign last   = (idx == IW'(NIB - 1));
    assign base   = {idx, 2'b00};
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    fulladder_4b u_slice (
        .A   (op_a[base +: 4]),
        .B   (op_b[base +: 4]),
        .Cex (carry),
        .S   (s_nib),
        .CO  (co)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is assigned before the case so every path drives it;
    // a missing assignment would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:           state_next = last ? ST_DONE : ST_RUN;
            default:          state_next = ST_IDLE;
        endcase
    end

    // NOTE: operand registers carry no reset; they are always loaded on an
    // accepted start before anything reads them, so a reset would add fanout
    // for no observable effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == ST_RUN) begin
            sum[base +: 4] <= s_nib;
            carry          <= co;
            idx            <= idx + IW'(1);
            if (last) begin
                cout <= co;
                // s_nib[3] is the final result MSB being written this edge.
                ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (s_nib[3] != op_a[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder (WIDTH=16). Expected results
// come from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum} from signed/unsigned integer math.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        int sa;
        int sb;
        int sr;
        int ur;
        logic [W-1:0] r;
        logic c;
        logic o;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ur = int'(ma) - int'(mb);
            c  = (ma >= mb);
            sr = sa - sb;
        end else begin
            ur = int'(ma) + int'(mb) + int'(mcin);
            c  = (ur >= (1 << W));
            sr = sa + sb + int'(mcin);
        end
        r = ur[W-1:0];
        o = (sr > 32767) || (sr < -32768);
        return {o, c, r};
    endfunction

    // Sample point: 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tcin, input logic tsub);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called at the sample point after the accepting edge. Counts cycles
    // until done (bounded) and the number of busy samples seen before it.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic op_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tcin, input logic tsub, input logic full);
        logic [W+1:0] exp;
        int lat;
        int bc;
        exp = model(ta, tb_, tcin, tsub);
        issue(ta, tb_, tcin, tsub);
        wait_done(lat, bc);
        if (full) begin
            check({tag, ".latency"}, lat, 4);
            check({tag, ".busy_cycles"}, bc, 4);
            check({tag, ".busy_in_done"}, {31'd0, busy}, 0);
        end
        check({tag, ".sum"}, {16'd0, sum}, {16'd0, exp[W-1:0]});
        check({tag, ".cout"}, {31'd0, cout}, {31'd0, exp[W]});
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp[W+1]});
    endtask

    initial begin
        logic [W+1:0] exp;
        logic [W+1:0] exp2;
        int lat;
        int bc;
        int seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        check("reset.busy", {31'd0, busy}, 0);
        check("reset.done", {31'd0, done}, 0);
        check("reset.sum",  {16'd0, sum}, 0);
        check("reset.cout", {31'd0, cout}, 0);
        check("reset.ovf",  {31'd0, ovf}, 0);

        // rst and start together: rst wins.
        start = 1'b1; a = 16'h1111; b = 16'h2222;
        tick();
        start = 1'b0;
        check("rst_start.busy", {31'd0, busy}, 0);
        rst = 1'b0;
        tick();

        op_and_check("basic_add",   16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        check("basic_add.sum_const", {16'd0, sum}, 32'h5555);
        tick();
        check("after_done.done", {31'd0, done}, 0);
        check("after_done.sum_hold", {16'd0, sum}, 32'h5555);

        op_and_check("ripple",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        op_and_check("carry_in",    16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        op_and_check("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        check("sub_borrow.sum_const", {16'd0, sum}, 32'hFFFE);
        op_and_check("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("add_ovf.ovf_const", {31'd0, ovf}, 1);
        op_and_check("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        check("sub_ovf.sum_const", {16'd0, sum}, 32'h7FFF);
        op_and_check("sub_min",     16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0);
        tick();

        // start during RUN with different operands is ignored.
        exp = model(16'hA5A5, 16'h0F0F, 1'b0, 1'b0);
        issue(16'hA5A5, 16'h0F0F, 1'b0, 1'b0);
        tick();
        a = 16'h1357; b = 16'h2468; sub = 1'b1; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done(lat, bc);
        check("ignore_start.latency", lat + 3, 4);
        check("ignore_start.sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
        check("ignore_start.cout", {31'd0, cout}, {31'd0, exp[W]});
        tick();

        // start in the DONE cycle is accepted; second done 5 cycles later.
        exp  = model(16'h00FF, 16'h0F01, 1'b1, 1'b0);
        exp2 = model(16'h3000, 16'h4001, 1'b0, 1'b1);
        issue(16'h00FF, 16'h0F01, 1'b1, 1'b0);
        wait_done(lat, bc);
        check("b2b.first_sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
        issue(16'h3000, 16'h4001, 1'b0, 1'b1);
        check("b2b.accepted_busy", {31'd0, busy}, 1);
        wait_done(lat, bc);
        check("b2b.gap", lat + 1, 5);
        check("b2b.second_sum", {16'd0, sum}, {16'd0, exp2[W-1:0]});
        check("b2b.second_ovf", {31'd0, ovf}, {31'd0, exp2[W+1]});
        tick();

        // Reset in cycle 2 of RUN: partial result discarded, no done pulse.
        issue(16'h7777, 16'h8888, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst.busy", {31'd0, busy}, 0);
        check("mid_rst.done", {31'd0, done}, 0);
        check("mid_rst.sum",  {16'd0, sum}, 0);
        check("mid_rst.cout", {31'd0, cout}, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            tick();
        end
        check("mid_rst.no_done", seen, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op_and_check("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), (i % 8) == 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wide adder/subtractor that computes a WIDTH-bit result by time-multiplexing one 4-bit carry-lookahead slice over WIDTH/4 cycles, one nibble per cycle, LSB first. The inter-nibble carry is held in a register. It sits between a requester using a start/done handshake and the team's 4-bit lookahead adder `fulladder_4b`. It trades latency for area where a full-width lookahead tree is not justified.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b (a+~b+1); captured on accepted start
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse, result valid
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  two's-complement overflow

One clock domain. Reset is synchronous and active-high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: accept the request and go to RUN.
  - Capture a into opA.
  - Capture opB = sub ? ~b : b.
  - Set carry reg = sub ? 1 : cin.
  - Set idx = 0.
- IDLE/DONE + start=0: DONE→IDLE, IDLE→IDLE. Outputs hold.
- RUN, each cycle: the slice adds opA[4*idx+:4] + opB[4*idx+:4] + carry.
  - On the edge: write sum[4*idx+:4] ← S, carry ← CO, idx ← idx+1.
  - When idx == WIDTH/4−1 on that edge: write cout ← CO, write ovf, and go to DONE.
- ovf = (opA[MSB] == opB[MSB]) && (final sum[MSB] != opA[MSB]), using the effective (possibly inverted) opB.
- start while busy=1 is ignored. No queuing, no error flag.
- sum nibbles update progressively during RUN. Only the value present while done=1 is architecturally valid.
- sum/cout/ovf hold after DONE until the next accepted start overwrites them.
- Arithmetic is modulo 2^WIDTH. The slice's carry-out is the only inter-nibble path.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
- Accepted start at edge E0. busy=1 from after E0 through edge E0+WIDTH/4.
- done=1 for exactly the cycle after edge E0+WIDTH/4. Latency is WIDTH/4 cycles, 4 for the default.
- busy=0 in the DONE cycle. A start sampled during DONE is accepted, giving back-to-back throughput of one op per WIDTH/4+1 cycles.
- Reset mid-RUN: the next cycle is IDLE with every output at its reset value. No done pulse. A partial result is discarded.
- rst and start in the same cycle: rst wins.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the NIB = WIDTH/4 derivation
  - an index-width function clog2(NIB)
- One sub-module: instantiate the existing `fulladder_4b` (ports A, B, Cex, S, CO) as the single datapath slice.
- Everything else (FSM, nibble mux, carry reg, result reg) lives in this module.

## Test plan
- Basic add: WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0.
  - Required: done exactly 4 cycles after start, sum=0x5555, cout=0, ovf=0, busy high 4 cycles.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0.
  - Required: sum=0x0000, cout=1, ovf=0.
- Carry-in: a=0x0000, b=0x0000, cin=1.
  - Required: sum=0x0001, cout=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (cin ignored).
  - Required: sum=0xFFFE, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0.
  - Required: sum=0x8000, ovf=1, cout=0.
- Overflow on subtract: a=0x8000, b=0x0001, sub=1.
  - Required: sum=0x7FFF, ovf=1, cout=1.
- Handshake edges:
  - start re-asserted during RUN with different operands → ignored, original result returned.
  - start in the DONE cycle → second op accepted, its done 5 cycles after the first done.
  - rst in cycle 2 of RUN → next cycle busy=0, done=0, sum=0, and no done pulse follows.
